// File: rtl/apb_slave_regbank.sv
// APB completer serving 16 x 32-bit registers (ID, write counter, 14 RW words)
// with programmable wait states. Define APB_SLVERR_EN to add the Pslverr port.
module apb_slave_regbank #(
  parameter int unsigned SEL_INDEX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
`ifdef APB_SLVERR_EN
  output logic        Pslverr,
`endif
  output logic        Pready
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  off_q;
  logic        write_q;
  logic        bad_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;
  logic [31:0] wcnt_q;
  logic [31:0] wcnt_d;
  logic [31:0] store_q [14];

  logic        sel;
  logic        in_range;
  logic [3:0]  off;
  logic        bad;
  logic [31:0] rd_word;
  logic        setup;
  logic        commit;

  assign sel      = Pselx[SEL_INDEX];
  assign off      = Paddr[5:2];
  assign in_range = (Paddr[31:6] == BASE_ADDR[31:6]);
  assign bad      = ~in_range | (Paddr[1:0] != 2'b00) | (Pwrite & (off < 4'd2));
  assign wcnt_d   = wcnt_q + 32'd1;

  always_comb begin
    rd_word = '0;
    if (!bad) begin
      if (off == 4'd0)      rd_word = ID_VALUE;
      else if (off == 4'd1) rd_word = wcnt_q;
      else                  rd_word = store_q[off - 4'd2];
    end
  end

  assign Pready = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef APB_SLVERR_EN
  assign Pslverr = bad_q & Pready;
`endif

  // Setup from IDLE, or Penable dropping while still selected in ACCESS,
  // both (re)start a transfer with fresh latches and a full wait count.
  assign setup  = sel & ~Penable;
  assign commit = (state_q == ACCESS) & sel & Penable & Pready & write_q & ~bad_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      write_q  <= 1'b0;
      bad_q    <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            off_q   <= off;
            write_q <= Pwrite;
            bad_q   <= bad;
            wdata_q <= Pwdata;
            cnt_q   <= WS;
            if (!Pwrite) prdata_q <= rd_word;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state_q <= IDLE;
          end else if (!Penable) begin
            off_q   <= off;
            write_q <= Pwrite;
            bad_q   <= bad;
            wdata_q <= Pwdata;
            cnt_q   <= WS;
            if (!Pwrite) prdata_q <= rd_word;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      wcnt_q <= '0;
      for (int unsigned i = 0; i < 14; i++) store_q[i] <= '0;
    end else if (commit) begin
      store_q[off_q - 4'd2] <= wdata_q;
      wcnt_q                <= wcnt_d;
    end
  end

  assign Prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench: three register-bank slaves on one APB bus (different selects and wait
// states), checked against an array-based model of the register map.
module tb_apb_slave_regbank;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int unsigned errors = 0;
  int unsigned checks = 0;

  int          ws_tab [3] = '{0, 3, 2};
  logic [31:0] mdl [3][16];
  logic [31:0] wcnt [3];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  apb_slave_regbank #(.SEL_INDEX(0), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) u_s0 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]),
`ifdef APB_SLVERR_EN
    .Pslverr(pslverr[0]),
`endif
    .Pready(pready[0]));

  apb_slave_regbank #(.SEL_INDEX(1), .BASE_ADDR(BASE), .WAIT_STATES(3), .ID_VALUE(ID)) u_s1 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]),
`ifdef APB_SLVERR_EN
    .Pslverr(pslverr[1]),
`endif
    .Pready(pready[1]));

  apb_slave_regbank #(.SEL_INDEX(2), .BASE_ADDR(BASE), .WAIT_STATES(2), .ID_VALUE(ID)) u_s2 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]),
`ifdef APB_SLVERR_EN
    .Pslverr(pslverr[2]),
`endif
    .Pready(pready[2]));

`ifndef APB_SLVERR_EN
  initial for (int i = 0; i < 3; i++) pslverr[i] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 16; r++) mdl[s][r] = 32'h0;
      wcnt[s]    = 32'h0;
      last_rd[s] = 32'h0;
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a, input bit wr);
    int unsigned word;
    word = (a / 4) % 16;
    return ((a >> 6) != (BASE >> 6)) || ((a % 4) != 0) || (wr && word < 2);
  endfunction

  function automatic logic [31:0] model_read(input int s, input logic [31:0] a);
    int unsigned word;
    word = (a / 4) % 16;
    if (addr_bad(a, 1'b0)) return 32'h0;
    if (word == 0) return ID;
    if (word == 1) return wcnt[s];
    return mdl[s][word];
  endfunction

  task automatic xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    int k;
    logic [31:0] exp;
    bit bad;
    bad = addr_bad(a, wr);
    @(negedge clk);
    psel = 3'b001 << s; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    k = 0;
    while (pready[s] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".waits"}, 32'(k), 32'(ws_tab[s]));
    if (!wr) begin
      exp = model_read(s, a);
      last_rd[s] = exp;
      chk({tag, ".rdata"}, prdata[s], exp);
    end else begin
      chk({tag, ".rdata_hold"}, prdata[s], last_rd[s]);
    end
`ifdef APB_SLVERR_EN
    chk({tag, ".slverr"}, 32'(pslverr[s]), 32'(bad));
`endif
    chk({tag, ".others_idle"}, 32'({pready[(s+1)%3], pready[(s+2)%3]}), 32'h0);
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
    if (wr && !bad) begin
      mdl[s][(a / 4) % 16] = d;
      wcnt[s] = wcnt[s] + 32'd1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int unsigned sl;
    int unsigned r;
    bit wr;

    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_reset();
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset.prdata", prdata[s], 32'h0);
      chk("reset.pready", 32'(pready[s]), 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xfer(0, 1'b0, 32'h8000_0000, 32'h0, "id_read");
    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, "wr_off2");
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, "rd_off2");
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, "rd_wcnt");

    xfer(1, 1'b1, 32'h8000_003C, 32'h1234_5678, "ws3_wr15");
    xfer(1, 1'b0, 32'h8000_003C, 32'h0, "ws3_rd15");

    xfer(0, 1'b1, 32'h8000_0004, 32'h1111_1111, "bad_ro");
    xfer(0, 1'b1, 32'h9000_0008, 32'h2222_2222, "bad_range");
    xfer(0, 1'b1, 32'h8000_0009, 32'h3333_3333, "bad_unalign");
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, "bad_wcnt");
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, "bad_off2");
    xfer(0, 1'b0, 32'h8000_0006, 32'h0, "bad_rd_unalign");

    // Abort: select dropped in the first wait cycle of slave 2.
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0014; pwdata = 32'h0000_00FF;
    @(negedge clk);
    penable = 1'b1;
    chk("abort.pready_low", 32'(pready[2]), 32'h0);
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    chk("abort.idle_pready", 32'(pready[2]), 32'h0);
    xfer(2, 1'b0, 32'h8000_0014, 32'h0, "abort_rd5");
    xfer(2, 1'b0, 32'h8000_0004, 32'h0, "abort_wcnt");
    xfer(2, 1'b1, 32'h8000_0014, 32'h0000_00AB, "after_abort_wr");
    xfer(2, 1'b0, 32'h8000_0014, 32'h0, "after_abort_rd");

    // Reset during a wait state of slave 1.
    @(negedge clk);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0008; pwdata = 32'hCAFE_0002;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int s = 0; s < 3; s++) begin
      chk("midrst.prdata", prdata[s], 32'h0);
      chk("midrst.pready", 32'(pready[s]), 32'h0);
    end
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h8000_0008, 32'h0, "postrst_rd2");
    xfer(1, 1'b0, 32'h8000_0004, 32'h0, "postrst_wcnt");

    for (int n = 0; n < 60; n++) begin
      sl = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      d  = $urandom;
      if (r < 8)       a = BASE + 32'($urandom_range(0, 15) * 4);
      else if (r == 8) a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 32'h9000_0000 + 32'($urandom_range(0, 15) * 4);
      xfer(int'(sl), wr, a, d, "rand");
    end
    for (int s = 0; s < 3; s++) xfer(s, 1'b0, 32'h8000_0004, 32'h0, "final_wcnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB completer (responder) for the APB master side of the AHB-to-APB bridge.
- Decodes one of the bridge's three Pselx lines and serves a bank of 16 x 32-bit registers with a programmable number of wait states.
- Gives the bridge team a realistic peripheral for system-level bring-up, and serves as a template for future peripherals.

Parameters:
- SEL_INDEX, 0, which bit of Pselx[2:0] selects this slave (0..2).
- BASE_ADDR, 32'h8000_0000, slave base address; decode compares Paddr[31:6] with BASE_ADDR[31:6].
- WAIT_STATES, 0, extra ACCESS cycles with Pready low before completion (0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- Hclk  input  1  system clock; all flops rise-edge.
- Hresetn  input  1  asynchronous active-low reset.
- Pselx  input  3  APB selects from bridge; this slave uses Pselx[SEL_INDEX].
- Penable  input  1  APB enable (access phase).
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  APB address.
- Pwdata  input  32  APB write data.
- Prdata  output  32  APB read data.
- Pready  output  1  transfer complete.
- Pslverr  output  1  error response; exists only when APB_SLVERR_EN is defined.

Behaviour:
- Reset (Hresetn=0, async):
  - state=IDLE; wait counter=0; regs[2..15]=0; write counter=0.
  - Prdata=0, Pready=0, Pslverr=0.
- Register map (word offset Paddr[5:2]):
  - 0 = ID_VALUE (RO).
  - 1 = write counter (RO): +1 on every committed write to offsets 2..15; wraps FFFF_FFFF->0.
  - 2..15 = RW storage.
- hit = Pselx[SEL_INDEX] & (Paddr[31:6]==BASE_ADDR[31:6]).
- bad = ~hit_range | (Paddr[1:0]!=0) | (Pwrite & offset<2).
- FSM IDLE:
  - On sel & ~Penable (setup phase): latch Paddr, Pwrite, Pwdata, bad; cnt<=WAIT_STATES; go to ACCESS.
  - If the transfer is a read, load Prdata with the addressed word in this cycle. Load 0 if bad.
- FSM ACCESS:
  - Pready = (cnt==0), combinational from state/cnt; 0 in IDLE.
  - If cnt!=0: cnt decrements each cycle.
  - On sel & Penable & Pready:
    - If the latched access is a write and not bad, commit latched Pwdata to the latched offset and bump the write counter.
    - Go to IDLE.
  - A back-to-back setup in the cycle after completion is accepted from IDLE.
- Latency: write commits at the end of access cycle 1+WAIT_STATES. Read data is stable from the first access cycle, so it is valid whenever Pready=1.
- Prdata holds its last read value between transfers; writes never alter Prdata.
- Bad writes are silently dropped; bad reads return 0.
- Abort: Psel low during ACCESS -> return to IDLE immediately; no commit, no counter increment.
- Penable low while Psel stays high in ACCESS (protocol violation) -> treat as a new setup: relatch and restart cnt.
- Transfers to other Pselx bits are ignored entirely.
- Reset mid-transfer: transfer discarded, all state to reset values.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - Pslverr port exists. Pslverr = latched bad & Pready & state==ACCESS; 0 otherwise.
  - Bad write still dropped; bad read still returns 0.
- Not defined: port absent; errors silent.

Test Plan:
- Reset, then read offset 0 (Paddr=8000_0000), WAIT_STATES=0 -> Pready=1 on first access cycle; Prdata=A5B0_0001.
- Write 8000_0008<=DEAD_BEEF, then read it back -> Prdata=DEAD_BEEF; offset-1 read returns 1.
- WAIT_STATES=3, write 8000_003C<=1234_5678 -> Pready low for 3 access cycles, high on the 4th; reg15=1234_5678 only after that edge.
- Write to 8000_0004 (RO), to 9000_0008 (out of range), and to 8000_0009 (unaligned) -> no register change; write counter unchanged; with APB_SLVERR_EN, Pslverr=1 coincident with Pready for each.
- Deassert Pselx mid-ACCESS with WAIT_STATES=2 on a write of 0000_00FF to offset 5 -> reg5 stays 0; counter unchanged; the next normal transfer completes correctly.
- Assert Hresetn=0 during a write's wait state, then read offset 2 after release -> reg2=0; Prdata=0 and Pready=0 during reset.
